// File: rtl/regfile_sb.sv
// Multi-read-port register file with a 2-bit per-register write scoreboard.
// Define REGFILE_BYPASS_EN to forward write-back data and post-writeback busy to the read ports.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 15,
    parameter int NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_dest,
    input  logic [DATA_W-1:0]        wb_value,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_dest,
    output logic                     iss_ready,
    input  logic                     flush
);

    localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [1:0]          cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic                wb_hit;
    logic                iss_in_range;
    logic                iss_accept;

    assign wb_hit       = wb_en && ({1'b0, wb_dest} < REG_LIMIT);
    assign iss_in_range = ({1'b0, iss_dest} < REG_LIMIT);

    always_comb begin
        iss_ready = 1'b0;
        if (iss_in_range) begin
            iss_ready = (cnt[iss_dest] != 2'd3);
        end
    end

    // A flush in the same cycle wins over a new reservation.
    assign iss_accept = iss_en && iss_ready && !flush;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = iss_accept && (iss_dest == ADDR_W'(r));
            dec_vec[r] = wb_hit && (wb_dest == ADDR_W'(r)) && (cnt[r] != 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_W'(i);
            end
        end else if (wb_hit) begin
            regs[wb_dest] <= wb_value;
        end
    end

    // Simultaneous reserve and release on one register cancel out.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst || flush) begin
                cnt[r] <= 2'd0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                cnt[r] <= cnt[r] + 2'd1;
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt[r] <= cnt[r] - 2'd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              in_range;
        logic [DATA_W-1:0] port_data;
        logic              port_busy;

        assign addr     = rd_addr[k*ADDR_W +: ADDR_W];
        assign in_range = ({1'b0, addr} < REG_LIMIT);

        always_comb begin
            port_data = '0;
            port_busy = 1'b0;
            if (in_range) begin
`ifdef REGFILE_BYPASS_EN
                port_data = regs[addr];
                if (wb_hit && (wb_dest == addr)) begin
                    port_data = wb_value;
                end
                port_busy = ((cnt[addr] - {1'b0, dec_vec[addr]}) != 2'd0);
`else
                port_data = regs[addr];
                port_busy = (cnt[addr] != 2'd0);
`endif
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = port_data;
        assign rd_busy[k]                  = port_busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: per-cycle comparison against an array model plus directed literal checks.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        iss_en;
    logic [3:0]  iss_dest;
    logic        iss_ready;
    logic        flush;

    int tests_run = 0;
    int fails     = 0;

    int m_reg [15];
    int m_cnt [15];
    bit model_valid = 0;

    regfile_sb #(
        .DATA_W(32), .ADDR_W(4), .NUM_REGS(15), .NUM_RD(2)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .iss_en(iss_en), .iss_dest(iss_dest), .iss_ready(iss_ready),
        .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic wbe, input logic [3:0] wbd,
                                 input logic [31:0] wbv, input logic isse, input logic [3:0] issd,
                                 input logic fl, input logic [3:0] a0, input logic [3:0] a1);
        @(posedge clk);
        #1;
        rst      = r;
        wb_en    = wbe;
        wb_dest  = wbd;
        wb_value = wbv;
        iss_en   = isse;
        iss_dest = issd;
        flush    = fl;
        rd_addr  = {a1, a0};
        #2;
    endtask

    task automatic idle(input logic [3:0] a0, input logic [3:0] a1);
        applyStimulus(0, 0, 4'd0, 32'd0, 0, a0, 0, a0, a1);
    endtask

    // Model state advances at each edge using the inputs seen at that edge.
    always @(posedge clk) begin
        int  acc_dest;
        int  dec_dest;
        bit  acc;
        bit  dec;
        bit  wbv;
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                m_reg[i] = i;
                m_cnt[i] = 0;
            end
            model_valid = 1;
        end else if (model_valid) begin
            wbv      = wb_en && (wb_dest < 15);
            acc      = iss_en && (iss_dest < 15) && !flush;
            acc_dest = int'(iss_dest);
            dec_dest = int'(wb_dest);
            if (acc) acc = (m_cnt[acc_dest] != 3);
            dec = wbv && (m_cnt[dec_dest] > 0);
            if (wbv) m_reg[dec_dest] = int'(wb_value);
            if (flush) begin
                for (int i = 0; i < 15; i++) m_cnt[i] = 0;
            end else begin
                if (acc) m_cnt[acc_dest] = m_cnt[acc_dest] + 1;
                if (dec) m_cnt[dec_dest] = m_cnt[dec_dest] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int k = 0; k < 2; k++) begin
                int          a;
                logic [31:0] exp_data;
                logic        exp_busy;
                a        = int'(rd_addr[k*4 +: 4]);
                exp_data = 32'd0;
                exp_busy = 1'b0;
                if (a < 15) begin
                    exp_data = m_reg[a];
                    exp_busy = (m_cnt[a] != 0);
`ifdef REGFILE_BYPASS_EN
                    if (wb_en && int'(wb_dest) == a) begin
                        exp_data = wb_value;
                        exp_busy = ((m_cnt[a] - ((m_cnt[a] > 0) ? 1 : 0)) != 0);
                    end
`endif
                end
                checkOutput($sformatf("model rd_data%0d", k), rd_data[k*32 +: 32], exp_data);
                checkOutput($sformatf("model rd_busy%0d", k), {31'd0, rd_busy[k]}, {31'd0, exp_busy});
            end
            checkOutput("model iss_ready", {31'd0, iss_ready},
                        {31'd0, (iss_dest < 15) && (m_cnt[int'(iss_dest)] != 3)});
        end
    end

    initial begin
        rst = 1'b1; wb_en = 0; wb_dest = 0; wb_value = 0;
        iss_en = 0; iss_dest = 0; flush = 0; rd_addr = 0;

        applyStimulus(1, 0, 4'd0, 32'd0, 0, 4'd0, 0, 4'd0, 4'd0);
        applyStimulus(1, 1, 4'd2, 32'hBEEF, 1, 4'd2, 1, 4'd0, 4'd0);

        // Post-reset sweep of every address on both ports.
        for (int i = 0; i < 16; i++) begin
            idle(4'(i), 4'(15 - i));
            checkOutput("reset data0", rd_data[31:0], (i < 15) ? 32'(i) : 32'd0);
            checkOutput("reset data1", rd_data[63:32], (i > 0) ? 32'(15 - i) : 32'd0);
            checkOutput("reset busy", {30'd0, rd_busy}, 32'd0);
            checkOutput("reset iss_ready", {31'd0, iss_ready}, (i < 15) ? 32'd1 : 32'd0);
        end

        // r3: counts 1,2,2,1,0.
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd3, 0, 4'd0, 4'd3);
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd3, 0, 4'd0, 4'd3);
        checkOutput("r3 busy cnt1", {31'd0, rd_busy[1]}, 32'd1);
        applyStimulus(0, 1, 4'd3, 32'hDEAD, 1, 4'd3, 0, 4'd0, 4'd3);
        checkOutput("r3 busy cnt2", {31'd0, rd_busy[1]}, 32'd1);
        applyStimulus(0, 1, 4'd3, 32'hDEAD, 0, 4'd3, 0, 4'd0, 4'd3);
        checkOutput("r3 busy cnt2b", {31'd0, rd_busy[1]}, 32'd1);
        applyStimulus(0, 1, 4'd3, 32'hDEAD, 0, 4'd3, 0, 4'd0, 4'd3);
`ifdef REGFILE_BYPASS_EN
        checkOutput("r3 busy last wb", {31'd0, rd_busy[1]}, 32'd0);
`else
        checkOutput("r3 busy last wb", {31'd0, rd_busy[1]}, 32'd1);
`endif
        idle(4'd0, 4'd3);
        checkOutput("r3 busy final", {31'd0, rd_busy[1]}, 32'd0);
        checkOutput("r3 data final", rd_data[63:32], 32'hDEAD);

        // r5: saturates at three reservations.
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd5, 0, 4'd5, 4'd0);
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd5, 0, 4'd5, 4'd0);
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd5, 0, 4'd5, 4'd0);
        checkOutput("r5 ready cnt2", {31'd0, iss_ready}, 32'd1);
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd5, 0, 4'd5, 4'd0);
        checkOutput("r5 ready cnt3", {31'd0, iss_ready}, 32'd0);
        applyStimulus(0, 1, 4'd5, 32'h55, 0, 4'd5, 0, 4'd0, 4'd0);
        checkOutput("r5 ready dropped", {31'd0, iss_ready}, 32'd0);
        applyStimulus(0, 1, 4'd5, 32'h55, 0, 4'd5, 0, 4'd0, 4'd0);
        applyStimulus(0, 1, 4'd5, 32'h55, 0, 4'd5, 0, 4'd0, 4'd0);
        idle(4'd5, 4'd0);
        checkOutput("r5 busy cleared", {31'd0, rd_busy[0]}, 32'd0);
        checkOutput("r5 ready again", {31'd0, iss_ready}, 32'd1);

        // r7: same-cycle read of a write-back.
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd7, 0, 4'd7, 4'd0);
        applyStimulus(0, 1, 4'd7, 32'h1234, 0, 4'd7, 0, 4'd7, 4'd0);
`ifdef REGFILE_BYPASS_EN
        checkOutput("r7 same data", rd_data[31:0], 32'h1234);
        checkOutput("r7 same busy", {31'd0, rd_busy[0]}, 32'd0);
`else
        checkOutput("r7 same data", rd_data[31:0], 32'd7);
        checkOutput("r7 same busy", {31'd0, rd_busy[0]}, 32'd1);
`endif
        idle(4'd7, 4'd0);
        checkOutput("r7 next data", rd_data[31:0], 32'h1234);
        checkOutput("r7 next busy", {31'd0, rd_busy[0]}, 32'd0);

        // Flush with concurrent write-back and issue.
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd2, 0, 4'd2, 4'd9);
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd9, 0, 4'd2, 4'd9);
        applyStimulus(0, 1, 4'd4, 32'hA5A5, 1, 4'd6, 1, 4'd2, 4'd9);
        checkOutput("flush pre busy", {30'd0, rd_busy}, 32'd3);
        idle(4'd2, 4'd9);
        checkOutput("flush post busy", {30'd0, rd_busy}, 32'd0);
        idle(4'd4, 4'd6);
        checkOutput("flush r4 data", rd_data[31:0], 32'hA5A5);
        checkOutput("flush r6 busy", {31'd0, rd_busy[1]}, 32'd0);

        // Out-of-range write-back and issue have no effect.
        applyStimulus(0, 1, 4'd15, 32'hBAD, 1, 4'd15, 0, 4'd15, 4'd14);
        checkOutput("oor iss_ready", {31'd0, iss_ready}, 32'd0);
        idle(4'd15, 4'd14);
        checkOutput("oor data15", rd_data[31:0], 32'd0);
        checkOutput("oor data14", rd_data[63:32], 32'd14);

        // Write-back with no reservation must not underflow.
        applyStimulus(0, 1, 4'd8, 32'h88, 0, 4'd8, 0, 4'd8, 4'd0);
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd8, 0, 4'd8, 4'd0);
        idle(4'd8, 4'd0);
        checkOutput("r8 busy", {31'd0, rd_busy[0]}, 32'd1);
        checkOutput("r8 data", rd_data[31:0], 32'h88);

        // Reset overrides a pending write-back and issue.
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 4'd1, 0, 4'd1, 4'd8);
        applyStimulus(1, 1, 4'd1, 32'hFFFF, 1, 4'd1, 0, 4'd1, 4'd8);
        idle(4'd1, 4'd8);
        checkOutput("rst r1 data", rd_data[31:0], 32'd1);
        checkOutput("rst r1 busy", {31'd0, rd_busy[0]}, 32'd0);
        checkOutput("rst r8 data", rd_data[63:32], 32'd8);
        checkOutput("rst r8 busy", {31'd0, rd_busy[1]}, 32'd0);

        idle(4'd0, 4'd0);
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
